capture_ctrl: RTL and testbench

- Sequencer that drives the frame-capture state machine through its start/done/ack handshake.
- Captures a programmed number of frames, or runs continuously, in response to CPU register commands.
- Counts completed frames, applies a per-frame timeout, supports graceful abort, and raises an end-of-sequence interrupt.
- Sits between the CPU register interface and the capture SM's start/done/ack pins.

---
 rtl/capture_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_capture_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: sequencer for the frame-capture state machine.
// It runs the start/done/ack handshake for a programmed number of frames, or
// continuously when cmd_nframes is 0. It counts completed frames, times out a
// stuck frame, stops gracefully on abort and pulses irq when a sequence ends.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   cmd_go       one-cycle pulse: start a capture sequence (accepted in IDLE only)
//   cmd_abort    one-cycle pulse: stop after the frame in progress
//   cmd_nframes  number of frames to capture; 0 = continuous until abort
//   timeout_cyc  maximum WAIT_DONE cycles per frame; 0 = no timeout
//   cap_done     done from the capture SM; held high until acked
//   cap_start    start to the capture SM
//   cap_ack      ack to the capture SM
//   busy         high in every state except IDLE
//   frames_done  frames completed in the current or last sequence
//   frame_pulse  one-cycle pulse per completed frame
//   err_timeout  sticky timeout flag; cleared by the next accepted cmd_go
//   irq          one-cycle pulse at sequence end (normal, abort or timeout)
module capture_ctrl #(
  parameter int unsigned FRAME_CNT_W = 8,
  parameter int unsigned TIMEOUT_W   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_go,
  input  logic                   cmd_abort,
  input  logic [FRAME_CNT_W-1:0] cmd_nframes,
  input  logic [TIMEOUT_W-1:0]   timeout_cyc,
  input  logic                   cap_done,
  output logic                   cap_start,
  output logic                   cap_ack,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   frame_pulse,
  output logic                   err_timeout,
  output logic                   irq
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACK       = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_FINISH    = 3'd6
  } state_e;

  state_e                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] nframes_q, nframes_d;
  logic [FRAME_CNT_W-1:0] frames_done_q, frames_done_d;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic                   abort_pend_q, abort_pend_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   cap_start_q, cap_start_d;
  logic                   cap_ack_q, cap_ack_d;
  logic                   busy_q, busy_d;
  logic                   frame_pulse_q, frame_pulse_d;
  logic                   irq_q, irq_d;

  logic                   tmo_hit_c;
  logic                   last_frame_c;

  // Timeout fires on the last permitted WAIT_DONE cycle.
  assign tmo_hit_c = (timeout_cyc != '0) &&
                     (tmo_cnt_q == (timeout_cyc - TIMEOUT_W'(1)));

  // Programmed count reached; never true in continuous mode.
  assign last_frame_c = (nframes_q != '0) && (frames_done_q == nframes_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d       = state_q;
    nframes_d     = nframes_q;
    frames_done_d = frames_done_q;
    tmo_cnt_d     = tmo_cnt_q;
    abort_pend_d  = abort_pend_q;
    err_timeout_d = err_timeout_q;

    // Abort is only remembered; it takes effect at the next frame boundary.
    if ((state_q != ST_IDLE) && cmd_abort) begin
      abort_pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          // A coincident stale done is consumed as this sequence's first frame.
          nframes_d     = cmd_nframes;
          frames_done_d = '0;
          err_timeout_d = 1'b0;
          abort_pend_d  = 1'b0;
          state_d       = ST_START;
        end else if (cap_done) begin
          // Late done left behind by a timed-out frame.
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        tmo_cnt_d = tmo_cnt_q + TIMEOUT_W'(1);
        if (cap_done) begin
          state_d = ST_ACK;
        end else if (tmo_hit_c) begin
          err_timeout_d = 1'b1;
          state_d       = ST_FINISH;
        end
      end
      ST_ACK: begin
        frames_done_d = frames_done_q + FRAME_CNT_W'(1);
        state_d       = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!cap_done) begin
          if (abort_pend_q || last_frame_c) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    cap_start_d   = (state_d == ST_START);
    cap_ack_d     = (state_d == ST_ACK) || (state_d == ST_FLUSH);
    frame_pulse_d = (state_d == ST_ACK);
    irq_d         = (state_d == ST_FINISH);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      nframes_q     <= '0;
      frames_done_q <= '0;
      tmo_cnt_q     <= '0;
      abort_pend_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      cap_start_q   <= 1'b0;
      cap_ack_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_pulse_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      nframes_q     <= nframes_d;
      frames_done_q <= frames_done_d;
      tmo_cnt_q     <= tmo_cnt_d;
      abort_pend_q  <= abort_pend_d;
      err_timeout_q <= err_timeout_d;
      cap_start_q   <= cap_start_d;
      cap_ack_q     <= cap_ack_d;
      busy_q        <= busy_d;
      frame_pulse_q <= frame_pulse_d;
      irq_q         <= irq_d;
    end
  end

  assign cap_start   = cap_start_q;
  assign cap_ack     = cap_ack_q;
  assign busy        = busy_q;
  assign frames_done = frames_done_q;
  assign frame_pulse = frame_pulse_q;
  assign err_timeout = err_timeout_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed testbench for capture_ctrl with a small capture-SM model.
module tb_capture_ctrl;

  localparam int unsigned FW = 4;
  localparam int unsigned TW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_go;
  logic          cmd_abort;
  logic [FW-1:0] cmd_nframes;
  logic [TW-1:0] timeout_cyc;
  logic          cap_done;
  logic          cap_start;
  logic          cap_ack;
  logic          busy;
  logic [FW-1:0] frames_done;
  logic          frame_pulse;
  logic          err_timeout;
  logic          irq;

  int checks = 0;
  int errors = 0;

  capture_ctrl #(.FRAME_CNT_W(FW), .TIMEOUT_W(TW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_go      (cmd_go),
    .cmd_abort   (cmd_abort),
    .cmd_nframes (cmd_nframes),
    .timeout_cyc (timeout_cyc),
    .cap_done    (cap_done),
    .cap_start   (cap_start),
    .cap_ack     (cap_ack),
    .busy        (busy),
    .frames_done (frames_done),
    .frame_pulse (frame_pulse),
    .err_timeout (err_timeout),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Capture SM model: raises done done_dly cycles after start, drops it on ack.
  logic model_en;
  int   done_dly;
  logic pend;
  int   mcnt;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      cap_done <= 1'b0;
      pend     <= 1'b0;
      mcnt     <= 0;
    end else begin
      if (cap_ack) cap_done <= 1'b0;
      if (cap_start) begin
        pend <= 1'b1;
        mcnt <= 0;
      end else if (pend && model_en) begin
        if (mcnt >= done_dly - 1) begin
          cap_done <= 1'b1;
          pend     <= 1'b0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // Observations from the most recent watch() run.
  int n_start, n_ack, n_pulse, n_irq;
  int start1_cyc, ack1_cyc, irq_cyc, last_ack_cyc;
  logic err_at_irq;

  task automatic pulse_go();
    cmd_go = 1'b1;
    @(negedge clk);
    cmd_go = 1'b0;
  endtask

  // Steps cycles until busy drops, counting handshake events. Optional abort
  // after the abort_start-th cap_start (delayed abort_dly cycles) and an
  // optional cmd_go pulse while busy at cycle go_busy_at.
  task automatic watch(input int max_cyc, input int abort_start,
                       input int abort_dly, input int go_busy_at);
    int cyc;
    int abort_cnt;
    cyc = 0; abort_cnt = -1;
    n_start = 0; n_ack = 0; n_pulse = 0; n_irq = 0;
    start1_cyc = -1; ack1_cyc = -1; irq_cyc = -1; last_ack_cyc = -1;
    err_at_irq = 1'b0;
    checks++;
    forever begin
      cmd_go    = 1'b0;
      cmd_abort = 1'b0;
      if (cap_start) begin
        n_start++;
        if (n_start == 1) start1_cyc = cyc;
        if (n_start == abort_start) abort_cnt = abort_dly;
      end
      if (abort_cnt == 0) begin
        cmd_abort = 1'b1;
        abort_cnt = -1;
      end else if (abort_cnt > 0) begin
        abort_cnt--;
      end
      if ((go_busy_at != 0) && (cyc == go_busy_at)) cmd_go = 1'b1;
      if (cap_ack) begin
        n_ack++;
        if (n_ack == 1) ack1_cyc = cyc;
        last_ack_cyc = cyc;
      end
      if (frame_pulse) n_pulse++;
      if (irq) begin
        n_irq++;
        irq_cyc    = cyc;
        err_at_irq = err_timeout;
      end
      if (!busy) break;
      if (cyc >= max_cyc) begin
        $display("FAIL watch_timeout: still busy after %0d cycles, required idle", cyc);
        errors++;
        break;
      end
      cyc++;
      @(negedge clk);
    end
    cmd_go    = 1'b0;
    cmd_abort = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cap_start, cap_ack, busy, frame_pulse, err_timeout, irq, frames_done} !== '0) begin
      $display("FAIL reset_outputs: got %b, required all 0",
               {cap_start, cap_ack, busy, frame_pulse, err_timeout, irq, frames_done});
      errors++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    cmd_nframes = FW'(1); timeout_cyc = '0; done_dly = 100; model_en = 1'b1;
    pulse_go();
    checks++;
    if (cap_start !== 1'b1) begin
      $display("FAIL go_latency: cap_start=%b, required 1", cap_start);
      errors++;
    end
    watch(400, 0, 0, 0);
    checks++;
    if ({n_start, n_ack, n_pulse, n_irq} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      $display("FAIL single_counts: start=%0d ack=%0d pulse=%0d irq=%0d, required 1 1 1 1",
               n_start, n_ack, n_pulse, n_irq);
      errors++;
    end
    checks++;
    if (ack1_cyc - start1_cyc !== 101) begin
      $display("FAIL single_ack_latency: %0d cycles start->ack, required 101",
               ack1_cyc - start1_cyc);
      errors++;
    end
    checks++;
    if (frames_done !== FW'(1) || err_timeout !== 1'b0) begin
      $display("FAIL single_final: frames_done=%0d err_timeout=%b, required 1 0",
               frames_done, err_timeout);
      errors++;
    end
  endtask

  task automatic test_multi();
    cmd_nframes = FW'(3); timeout_cyc = '0; done_dly = 7; model_en = 1'b1;
    pulse_go();
    watch(400, 0, 0, 0);
    checks++;
    if ({n_start, n_ack, n_pulse, n_irq} !== {32'd3, 32'd3, 32'd3, 32'd1}) begin
      $display("FAIL multi_counts: start=%0d ack=%0d pulse=%0d irq=%0d, required 3 3 3 1",
               n_start, n_ack, n_pulse, n_irq);
      errors++;
    end
    checks++;
    if (frames_done !== FW'(3) || irq_cyc <= last_ack_cyc) begin
      $display("FAIL multi_final: frames_done=%0d irq_cyc=%0d last_ack=%0d, required 3 and irq after ack",
               frames_done, irq_cyc, last_ack_cyc);
      errors++;
    end
  endtask

  task automatic test_abort();
    cmd_nframes = '0; timeout_cyc = '0; done_dly = 10; model_en = 1'b1;
    pulse_go();
    watch(1000, 5, 4, 0);
    checks++;
    if ({n_start, n_ack, n_irq} !== {32'd5, 32'd5, 32'd1} || frames_done !== FW'(5)) begin
      $display("FAIL abort_counts: start=%0d ack=%0d irq=%0d frames_done=%0d, required 5 5 1 5",
               n_start, n_ack, n_irq, frames_done);
      errors++;
    end
  endtask

  task automatic test_timeout_flush();
    int waited;
    cmd_nframes = FW'(1); timeout_cyc = TW'(50); done_dly = 5; model_en = 1'b0;
    pulse_go();
    watch(300, 0, 0, 0);
    checks++;
    if (irq_cyc - start1_cyc !== 51 || err_at_irq !== 1'b1) begin
      $display("FAIL timeout_irq: start->irq=%0d err=%b, required 51 1",
               irq_cyc - start1_cyc, err_at_irq);
      errors++;
    end
    checks++;
    if (n_ack !== 0 || frames_done !== '0 || err_timeout !== 1'b1) begin
      $display("FAIL timeout_state: ack=%0d frames_done=%0d err=%b, required 0 0 1",
               n_ack, frames_done, err_timeout);
      errors++;
    end
    // Late done from the abandoned frame must be flushed from IDLE.
    model_en = 1'b1;
    waited = 0;
    while (!busy && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    watch(20, 0, 0, 0);
    checks++;
    if ({n_ack, n_pulse, n_irq} !== {32'd1, 32'd0, 32'd0} || frames_done !== '0 ||
        err_timeout !== 1'b1) begin
      $display("FAIL flush: ack=%0d pulse=%0d irq=%0d frames_done=%0d err=%b, required 1 0 0 0 1",
               n_ack, n_pulse, n_irq, frames_done, err_timeout);
      errors++;
    end
    cmd_nframes = FW'(1); timeout_cyc = '0; done_dly = 3;
    pulse_go();
    checks++;
    if (err_timeout !== 1'b0) begin
      $display("FAIL go_clears_err: err_timeout=%b, required 0", err_timeout);
      errors++;
    end
    watch(100, 0, 0, 0);
    checks++;
    if (frames_done !== FW'(1) || n_irq !== 1) begin
      $display("FAIL after_timeout_run: frames_done=%0d irq=%0d, required 1 1",
               frames_done, n_irq);
      errors++;
    end
  endtask

  task automatic test_wrap_busy_go();
    cmd_nframes = '0; timeout_cyc = '0; done_dly = 2; model_en = 1'b1;
    pulse_go();
    watch(2000, 17, 0, 30);
    checks++;
    if ({n_start, n_ack, n_irq} !== {32'd17, 32'd17, 32'd1} || frames_done !== FW'(1)) begin
      $display("FAIL wrap: start=%0d ack=%0d irq=%0d frames_done=%0d, required 17 17 1 1",
               n_start, n_ack, n_irq, frames_done);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    int seen;
    seen = 0;
    cmd_nframes = '0; timeout_cyc = '0; done_dly = 10; model_en = 1'b1;
    pulse_go();
    for (int i = 0; i < 200; i++) begin
      if (frame_pulse) seen++;
      if (seen == 2) break;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (frames_done !== FW'(2) || busy !== 1'b1) begin
      $display("FAIL pre_reset: frames_done=%0d busy=%b, required 2 1", frames_done, busy);
      errors++;
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cap_start, cap_ack, busy, frame_pulse, err_timeout, irq, frames_done} !== '0) begin
      $display("FAIL async_reset: got %b, required all 0",
               {cap_start, cap_ack, busy, frame_pulse, err_timeout, irq, frames_done});
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmd_nframes = FW'(1); done_dly = 5;
    pulse_go();
    watch(100, 0, 0, 0);
    checks++;
    if (frames_done !== FW'(1) || n_start !== 1 || n_irq !== 1) begin
      $display("FAIL post_reset_run: frames_done=%0d start=%0d irq=%0d, required 1 1 1",
               frames_done, n_start, n_irq);
      errors++;
    end
  endtask

  initial begin
    reset = 1'b0; cmd_go = 1'b0; cmd_abort = 1'b0;
    cmd_nframes = '0; timeout_cyc = '0;
    model_en = 1'b1; done_dly = 1;
    test_reset();
    test_single();
    test_multi();
    test_abort();
    test_timeout_flush();
    test_wrap_busy_go();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
